// File: rtl/dsp_mac_pipe_if.sv
// Operand, control and result bundle of the MAC slice; master drives beats, slave is the slice.
interface dsp_mac_pipe_if #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 24
);
  logic                        CE;
  logic                        IN_VALID;
  logic                        IN_FIRST;
  logic                        IN_LAST;
  logic                        SUB_PRE;
  logic signed [A_WIDTH-1:0]   A;
  logic signed [B_WIDTH-1:0]   B;
  logic signed [B_WIDTH-1:0]   D;
  logic                        CLR_OVF;
  logic                        OUT_VALID;
  logic signed [OUT_WIDTH-1:0] P;
  logic signed [ACC_WIDTH-1:0] ACC;
  logic                        SAT;
  logic                        OVF;

  modport master (
    output CE, IN_VALID, IN_FIRST, IN_LAST, SUB_PRE, A, B, D, CLR_OVF,
    input  OUT_VALID, P, ACC, SAT, OVF
  );

  modport slave (
    input  CE, IN_VALID, IN_FIRST, IN_LAST, SUB_PRE, A, B, D, CLR_OVF,
    output OUT_VALID, P, ACC, SAT, OVF
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed MAC: input reg, pre-add, product (MREG), accumulate, round/saturate output.
// Latency 4+MREG CE-high cycles, one beat per cycle; CE=0 freezes every stage, no backpressure.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 0,
  parameter int PRE_ADD   = 1,
  parameter int MREG      = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  dsp_mac_pipe_if.slave bus
);
  localparam int PW = B_WIDTH + 1;
  localparam int MW = A_WIDTH + B_WIDTH + 1;
  localparam int RW = ACC_WIDTH + 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] HALF = (SHIFT > 0) ? (RW'(1) << RS) : '0;
  localparam logic signed [RW-1:0] P_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] P_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // S1: input register
  logic                      s1_vld_q, s1_first_q, s1_last_q, s1_sub_q;
  logic signed [A_WIDTH-1:0] s1_a_q;
  logic signed [B_WIDTH-1:0] s1_b_q, s1_d_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_d_q     <= '0;
    end else if (bus.CE) begin
      s1_vld_q   <= bus.IN_VALID;
      s1_first_q <= bus.IN_FIRST;
      s1_last_q  <= bus.IN_LAST;
      s1_sub_q   <= bus.SUB_PRE;
      s1_a_q     <= bus.A;
      s1_b_q     <= bus.B;
      s1_d_q     <= bus.D;
    end
  end

  // S2: pre-adder, one bit wider than B so D+B / D-B never wraps
  logic signed [PW-1:0]      pre_d, s2_pre_q;
  logic signed [A_WIDTH-1:0] s2_a_q;
  logic                      s2_vld_q, s2_first_q, s2_last_q;

  always_comb begin
    pre_d = {s1_b_q[B_WIDTH-1], s1_b_q};
    if (PRE_ADD != 0) begin
      if (s1_sub_q) begin
        pre_d = {s1_d_q[B_WIDTH-1], s1_d_q} - {s1_b_q[B_WIDTH-1], s1_b_q};
      end else begin
        pre_d = {s1_d_q[B_WIDTH-1], s1_d_q} + {s1_b_q[B_WIDTH-1], s1_b_q};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_pre_q   <= '0;
      s2_a_q     <= '0;
    end else if (bus.CE) begin
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_pre_q   <= pre_d;
      s2_a_q     <= s1_a_q;
    end
  end

  // S3: product, registered or passed straight through
  logic signed [MW-1:0] prod_d, s3_prod;
  logic                 s3_vld, s3_first, s3_last;

  assign prod_d = MW'(s2_pre_q) * MW'(s2_a_q);

  generate
    if (MREG != 0) begin : g_mreg
      logic signed [MW-1:0] s3_prod_q;
      logic                 s3_vld_q, s3_first_q, s3_last_q;

      always_ff @(posedge CLK) begin
        if (!RSTN) begin
          s3_prod_q  <= '0;
          s3_vld_q   <= 1'b0;
          s3_first_q <= 1'b0;
          s3_last_q  <= 1'b0;
        end else if (bus.CE) begin
          s3_prod_q  <= prod_d;
          s3_vld_q   <= s2_vld_q;
          s3_first_q <= s2_first_q;
          s3_last_q  <= s2_last_q;
        end
      end

      assign s3_prod  = s3_prod_q;
      assign s3_vld   = s3_vld_q;
      assign s3_first = s3_first_q;
      assign s3_last  = s3_last_q;
    end else begin : g_comb
      assign s3_prod  = prod_d;
      assign s3_vld   = s2_vld_q;
      assign s3_first = s2_first_q;
      assign s3_last  = s2_last_q;
    end
  endgenerate

  // S4: accumulator with sticky signed-overflow flag
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_ext, acc_sum;
  logic                        ovf_q, ovf_d, ovf_ev;
  logic                        s4_vld_q, s4_last_q;

  always_comb begin
    prod_ext = ACC_WIDTH'(s3_prod);
    acc_sum  = acc_q + prod_ext;
    ovf_ev   = s3_vld && !s3_first &&
               (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_d = acc_q;
    if (bus.CE && s3_vld) begin
      acc_d = s3_first ? prod_ext : acc_sum;
    end
    // clearing is deliberately independent of CE; a set in the same cycle wins
    ovf_d = ovf_q;
    if (bus.CE && ovf_ev) begin
      ovf_d = 1'b1;
    end else if (bus.CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // S5: round-half-up, arithmetic shift, clamp to OUT_WIDTH
  logic signed [RW-1:0]        rnd, scaled;
  logic signed [OUT_WIDTH-1:0] p_q, p_d;
  logic                        sat_q, sat_d, ovld_q, ovld_d;

  always_comb begin
    rnd    = {acc_q[ACC_WIDTH-1], acc_q} + HALF;
    scaled = rnd >>> SHIFT;
    p_d    = p_q;
    sat_d  = sat_q;
    ovld_d = bus.CE && s4_vld_q && s4_last_q;
    if (ovld_d) begin
      if (scaled > P_MAX) begin
        p_d   = P_MAX[OUT_WIDTH-1:0];
        sat_d = 1'b1;
      end else if (scaled < P_MIN) begin
        p_d   = P_MIN[OUT_WIDTH-1:0];
        sat_d = 1'b1;
      end else begin
        p_d   = scaled[OUT_WIDTH-1:0];
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      s4_vld_q  <= 1'b0;
      s4_last_q <= 1'b0;
      p_q       <= '0;
      sat_q     <= 1'b0;
      ovld_q    <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      p_q    <= p_d;
      sat_q  <= sat_d;
      ovld_q <= ovld_d;
      if (bus.CE) begin
        s4_vld_q  <= s3_vld;
        s4_last_q <= s3_last;
      end
    end
  end

  assign bus.OUT_VALID = ovld_q;
  assign bus.P         = p_q;
  assign bus.ACC       = acc_q;
  assign bus.SAT       = sat_q;
  assign bus.OVF       = ovf_q;
endmodule
